ising_run_sequencer: RTL and testbench

Hardware controller that runs one complete Ising/max-cut solve on ising_axi without host bus cycles. It drains a queue of weight-write commands into the array's write port, programs the phase counters, and asserts START for a fixed number of cycles. It then stops the array, reads all N phases back and reduces them to an N-bit spin vector. It sits between a host or DMA command source and the ising_axi write/read ports.

---
 rtl/ising_run_sequencer_pkg.sv | 49 ++++
 rtl/ising_run_sequencer_cmd_fifo.sv | 57 +++++
 rtl/ising_run_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_ising_run_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_run_sequencer_pkg.sv
// ising_run_sequencer_pkg
// Shared definitions for the Ising run sequencer:
//   - state_t          : sequencer state encoding
//   - WADDR_*_SHIFT    : weight address composition (row/column shifts)
//   - PADDR_SHIFT      : phase read address stride shift
//   - *_ADDR           : ising_axi register map, mirrored from the ising_axi header
//   - weight_addr()    : WEIGHT_ADDR_BASE + (i << 2) + (j << 13)
//   - phase_addr()     : PHASE_ADDR_BASE + (k << 2)
// Optional macro: ISING_RESTART_EN adds the S_RESTART state.
package ising_run_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_CUT,
        S_CFG_MAX,
        S_LOAD_W,
        S_START,
`ifdef ISING_RESTART_EN
        S_RESTART,
`endif
        S_RUN,
        S_STOP,
        S_RD,
        S_DONE
    } state_t;

    localparam int unsigned WADDR_I_SHIFT = 2;
    localparam int unsigned WADDR_J_SHIFT = 13;
    localparam int unsigned PADDR_SHIFT   = 2;

    // ising_axi register map
    localparam logic [31:0] START_ADDR       = 32'h0000_0004;
    localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0008;
    localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_000C;
    localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0200;
    localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000;

    // START is held this many cycles in S_RESTART before the 0/1 rewrite
    localparam int unsigned RESTART_HOLD = 16;

    function automatic logic [31:0] weight_addr(input logic [31:0] i, input logic [31:0] j);
        return WEIGHT_ADDR_BASE + (i << WADDR_I_SHIFT) + (j << WADDR_J_SHIFT);
    endfunction

    function automatic logic [31:0] phase_addr(input logic [31:0] k);
        return PHASE_ADDR_BASE + (k << PADDR_SHIFT);
    endfunction

endpackage

// File: rtl/ising_run_sequencer_cmd_fifo.sv
// ising_cmd_fifo
// Synchronous first-word-fall-through FIFO for weight commands.
// Ports:
//   clk, rstn      : clock, synchronous active-low reset (clears pointers)
//   push, din      : write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop, dout      : read request; dout always shows the head entry
//   full, empty    : occupancy flags
module ising_cmd_fifo #(
    parameter int unsigned W     = 38,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ising_run_sequencer.sv
// ising_run_sequencer
// Runs one complete Ising/max-cut solve on ising_axi: drains queued weight
// commands into the write port, programs CTR_CUTOFF/CTR_MAX, holds START for
// run_cycles cycles, stops the array, reads N phases and thresholds them into
// an N-bit spin vector.
// Ports:
//   clk, axi_rstn            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready      : weight command handshake (cmd_i, cmd_j, cmd_w)
//   go                       : start a run (sampled in IDLE only)
//   cutoff/ctr_max/run_cycles: run configuration, latched on go
//   busy, done, spins        : status; spins valid from the done pulse
//   wready/wr_addr/wdata     : registered ising_axi write port
//   araddr/rdata             : ising_axi read port
// Optional macro: ISING_RESTART_EN inserts a 16-cycle hold plus START 0/1
// rewrite between START and RUN.
module ising_run_sequencer
    import ising_run_sequencer_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned IDXW      = 3,
    parameter int unsigned CMD_DEPTH = 16,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic            clk,
    input  logic            axi_rstn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IDXW-1:0] cmd_i,
    input  logic [IDXW-1:0] cmd_j,
    input  logic [31:0]     cmd_w,
    input  logic            go,
    input  logic [31:0]     cutoff,
    input  logic [31:0]     ctr_max,
    input  logic [31:0]     run_cycles,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    spins,
    output logic            wready,
    output logic [31:0]     wr_addr,
    output logic [31:0]     wdata,
    output logic [31:0]     araddr,
    input  logic [31:0]     rdata
);
    localparam int unsigned FW   = 2 * IDXW + 32;
    localparam int unsigned LATW = $clog2(READ_LAT + 1) + 1;

    state_t            state, state_d;
    logic              fifo_full, fifo_empty, pop;
    logic [FW-1:0]     fifo_dout;
    logic [IDXW-1:0]   f_i, f_j;
    logic [31:0]       f_w;
    logic [31:0]       cut_q, max_q, runc_q, cnt_q;
    logic [IDXW-1:0]   rd_k;
    logic [LATW-1:0]   lat_q;
    logic [N-1:0]      shadow, shadow_nxt, spins_q;
    logic              wready_q;
    logic [31:0]       wr_addr_q, wdata_q, araddr_q;
    logic              wr_en;
    logic [31:0]       wr_a, wr_d;
    logic              rd_sample, rd_last;
`ifdef ISING_RESTART_EN
    logic [4:0]        rs_cnt;
`endif

    ising_cmd_fifo #(.W(FW), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (axi_rstn),
        .push  (cmd_valid && cmd_ready),
        .din   ({cmd_i, cmd_j, cmd_w}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {f_i, f_j, f_w} = fifo_dout;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign spins     = spins_q;
    assign wready    = wready_q;
    assign wr_addr   = wr_addr_q;
    assign wdata     = wdata_q;
    assign araddr    = araddr_q;

    assign rd_sample = (state == S_RD) && (lat_q == LATW'(READ_LAT));
    assign rd_last   = rd_k == IDXW'(N - 1);

    always_comb begin
        shadow_nxt       = shadow;
        shadow_nxt[rd_k] = (rdata >= cut_q);
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_a    = wr_addr_q;
        wr_d    = wdata_q;
        case (state)
            S_IDLE: begin
                if (go) state_d = S_CFG_CUT;
            end
            S_CFG_CUT: begin
                wr_en   = 1'b1;
                wr_a    = CTR_CUTOFF_ADDR;
                wr_d    = cut_q;
                state_d = S_CFG_MAX;
            end
            S_CFG_MAX: begin
                wr_en   = 1'b1;
                wr_a    = CTR_MAX_ADDR;
                wr_d    = max_q;
                state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // Diagonal entries are consumed without a write
                    if (f_i != f_j) begin
                        wr_en = 1'b1;
                        wr_a  = weight_addr(32'(f_i), 32'(f_j));
                        wr_d  = f_w;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wr_en = 1'b1;
                wr_a  = START_ADDR;
                wr_d  = 32'd1;
`ifdef ISING_RESTART_EN
                state_d = S_RESTART;
`else
                state_d = S_RUN;
`endif
            end
`ifdef ISING_RESTART_EN
            S_RESTART: begin
                if (rs_cnt == 5'(RESTART_HOLD)) begin
                    wr_en = 1'b1;
                    wr_a  = START_ADDR;
                    wr_d  = 32'd0;
                end else if (rs_cnt == 5'(RESTART_HOLD + 1)) begin
                    wr_en   = 1'b1;
                    wr_a    = START_ADDR;
                    wr_d    = 32'd1;
                    state_d = S_RUN;
                end
            end
`endif
            S_RUN: begin
                if (cnt_q <= 32'd1) state_d = S_STOP;
            end
            S_STOP: begin
                wr_en   = 1'b1;
                wr_a    = START_ADDR;
                wr_d    = 32'd0;
                state_d = S_RD;
            end
            S_RD: begin
                if (rd_sample && rd_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            cut_q     <= '0;
            max_q     <= '0;
            runc_q    <= '0;
            cnt_q     <= '0;
            rd_k      <= '0;
            lat_q     <= '0;
            shadow    <= '0;
            spins_q   <= '0;
            wready_q  <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
`ifdef ISING_RESTART_EN
            rs_cnt    <= '0;
`endif
        end else begin
            wready_q  <= wr_en;
            wr_addr_q <= wr_a;
            wdata_q   <= wr_d;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        cut_q  <= cutoff;
                        max_q  <= ctr_max;
                        runc_q <= run_cycles;
                    end
                end
                S_START: begin
                    // A zero run length still spends one cycle in RUN
                    cnt_q <= (runc_q == 32'd0) ? 32'd1 : runc_q;
`ifdef ISING_RESTART_EN
                    rs_cnt <= '0;
`endif
                end
`ifdef ISING_RESTART_EN
                S_RESTART: begin
                    rs_cnt <= rs_cnt + 5'd1;
                end
`endif
                S_RUN: begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_STOP: begin
                    araddr_q <= phase_addr(32'd0);
                    rd_k     <= '0;
                    lat_q    <= '0;
                end
                S_RD: begin
                    if (rd_sample) begin
                        shadow <= shadow_nxt;
                        // spins loads on the RD->DONE edge so it is valid
                        // in the same cycle done is high
                        if (rd_last) begin
                            spins_q <= shadow_nxt;
                        end else begin
                            rd_k     <= rd_k + IDXW'(1);
                            araddr_q <= phase_addr(32'(rd_k) + 32'd1);
                            lat_q    <= '0;
                        end
                    end else begin
                        lat_q <= lat_q + LATW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_run_sequencer.sv
// tb_ising_run_sequencer
// Directed bench for ising_run_sequencer with a bench model of the ising_axi
// write/read ports. Build with ISING_RESTART_EN defined to expect the
// restart START sequence.
module tb_ising_run_sequencer;
    import ising_run_sequencer_pkg::*;

    localparam int N = 8;
    localparam int IDXW = 3;

    logic        clk, axi_rstn, cmd_valid, cmd_ready, go;
    logic [2:0]  cmd_i, cmd_j;
    logic [31:0] cmd_w, cutoff, ctr_max, run_cycles;
    logic        busy, done, wready;
    logic [7:0]  spins;
    logic [31:0] wr_addr, wdata, araddr, rdata;

    ising_run_sequencer #(.N(N), .IDXW(IDXW), .CMD_DEPTH(16), .READ_LAT(1)) dut (
        .clk(clk), .axi_rstn(axi_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_i(cmd_i), .cmd_j(cmd_j), .cmd_w(cmd_w),
        .go(go), .cutoff(cutoff), .ctr_max(ctr_max), .run_cycles(run_cycles),
        .busy(busy), .done(done), .spins(spins),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .araddr(araddr), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ising_axi read model: one cycle from araddr to rdata
    logic [31:0] phase_mem [8];
    always @(posedge clk) rdata <= phase_mem[3'((araddr - PHASE_ADDR_BASE) >> 2)];

    logic [31:0] wl_a[$], wl_d[$], rl[$], ea[$], ed[$];
    int          wl_c[$];
    logic [31:0] last_ar = '0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (wready) begin
            wl_a.push_back(wr_addr);
            wl_d.push_back(wdata);
            wl_c.push_back(cyc);
        end
        if (busy && araddr != last_ar) rl.push_back(araddr);
        last_ar = araddr;
        if (done) done_cnt++;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_logs();
        wl_a.delete(); wl_d.delete(); wl_c.delete(); rl.delete();
        ea.delete(); ed.delete();
        done_cnt = 0;
    endtask

    task automatic exp_head(input logic [31:0] c, input logic [31:0] m);
        ea.push_back(CTR_CUTOFF_ADDR); ed.push_back(c);
        ea.push_back(CTR_MAX_ADDR);    ed.push_back(m);
    endtask

    task automatic exp_w(input logic [2:0] i, input logic [2:0] j, input logic [31:0] w);
        ea.push_back(WEIGHT_ADDR_BASE + 32'(i) * 4 + 32'(j) * 8192);
        ed.push_back(w);
    endtask

    task automatic exp_tail();
        ea.push_back(START_ADDR); ed.push_back(32'd1);
`ifdef ISING_RESTART_EN
        ea.push_back(START_ADDR); ed.push_back(32'd0);
        ea.push_back(START_ADDR); ed.push_back(32'd1);
`endif
        ea.push_back(START_ADDR); ed.push_back(32'd0);
    endtask

    task automatic check_log(input string tag, input int run_len);
        int n;
        n = wl_a.size();
        chk({tag, "_nwrites"}, 64'(n), 64'(ea.size()));
        for (int k = 0; k < ea.size() && k < n; k++) begin
            chk($sformatf("%s_waddr%0d", tag, k), 64'(wl_a[k]), 64'(ea[k]));
            chk($sformatf("%s_wdata%0d", tag, k), 64'(wl_d[k]), 64'(ed[k]));
        end
        if (n >= 2) chk({tag, "_start_gap"}, 64'(wl_c[n-1] - wl_c[n-2]),
                        64'(((run_len == 0) ? 1 : run_len) + 1));
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_nreads"}, 64'(rl.size()), 64'd8);
        for (int k = 0; k < 8 && k < rl.size(); k++)
            chk($sformatf("%s_raddr%0d", tag, k), 64'(rl[k]), 64'(PHASE_ADDR_BASE + 32'(k) * 4));
    endtask

    task automatic push(input logic [2:0] i, input logic [2:0] j, input logic [31:0] w, output bit acc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_i = i; cmd_j = j; cmd_w = w;
        acc = cmd_ready;
    endtask

    task automatic idle_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic go_run(input logic [31:0] c, input logic [31:0] m, input logic [31:0] r);
        @(negedge clk);
        go = 1'b1; cutoff = c; ctr_max = m; run_cycles = r;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  i;
        logic [2:0]  j;
        logic [31:0] w;
        bit          wr;
    } vec_t;
    vec_t tbl[12];

    bit acc;

    initial begin
        // Max-cut graph A..H = 0..7, with a diagonal entry that must be dropped
        tbl[0]  = '{3'd0, 3'd1, 32'd1, 1'b1};  // AB
        tbl[1]  = '{3'd0, 3'd4, 32'd1, 1'b1};  // AE
        tbl[2]  = '{3'd0, 3'd7, 32'd4, 1'b1};  // AH
        tbl[3]  = '{3'd1, 3'd2, 32'd1, 1'b1};  // BC
        tbl[4]  = '{3'd1, 3'd3, 32'd1, 1'b1};  // BD
        tbl[5]  = '{3'd3, 3'd3, 32'd9, 1'b0};  // diagonal
        tbl[6]  = '{3'd1, 3'd7, 32'd4, 1'b1};  // BH
        tbl[7]  = '{3'd2, 3'd3, 32'd1, 1'b1};  // CD
        tbl[8]  = '{3'd2, 3'd7, 32'd4, 1'b1};  // CH
        tbl[9]  = '{3'd3, 3'd4, 32'd1, 1'b1};  // DE
        tbl[10] = '{3'd3, 3'd7, 32'd4, 1'b1};  // DH
        tbl[11] = '{3'd4, 3'd7, 32'd4, 1'b1};  // EH

        // Phases giving spins 8'b10001101 at cutoff 4 (phase 2 sits on the cutoff)
        phase_mem[0] = 32'd5; phase_mem[1] = 32'd3; phase_mem[2] = 32'd4; phase_mem[3] = 32'd8;
        phase_mem[4] = 32'd0; phase_mem[5] = 32'd1; phase_mem[6] = 32'd2; phase_mem[7] = 32'd7;

        cmd_valid = 0; cmd_i = '0; cmd_j = '0; cmd_w = '0;
        go = 0; cutoff = '0; ctr_max = '0; run_cycles = '0;
        axi_rstn = 0;
        idle_cycles(3);
        axi_rstn = 1;

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_spins", 64'(spins), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Full max-cut run
        clear_logs();
        exp_head(32'd4, 32'd8);
        for (int k = 0; k < 12; k++) begin
            push(tbl[k].i, tbl[k].j, tbl[k].w, acc);
            chk($sformatf("t1_push%0d", k), 64'(acc), 64'd1);
            if (tbl[k].wr) exp_w(tbl[k].i, tbl[k].j, tbl[k].w);
        end
        idle_cmd();
        exp_tail();
        go_run(32'd4, 32'd8, 32'd600);
        wait_done("t1", 2000);
        chk("t1_spins", 64'(spins), 64'h8D);
        idle_cycles(3);
        check_log("t1", 600);
        check_reads("t1");
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);

        // FIFO full: 16 accepted, 17th refused; run_cycles=0 behaves as 1
        phase_mem[0] = 32'd99;  phase_mem[1] = 32'd100; phase_mem[2] = 32'd101; phase_mem[3] = 32'd0;
        phase_mem[4] = 32'hFFFF_FFFF; phase_mem[5] = 32'd100; phase_mem[6] = 32'd1; phase_mem[7] = 32'd200;
        clear_logs();
        exp_head(32'd100, 32'd9);
        for (int k = 0; k < 16; k++) begin
            push(3'(k % 8), 3'((k + 1) % 8), 32'(k + 100), acc);
            chk($sformatf("t3_push%0d", k), 64'(acc), 64'd1);
            exp_w(3'(k % 8), 3'((k + 1) % 8), 32'(k + 100));
        end
        push(3'd6, 3'd5, 32'd999, acc);
        chk("t3_push_full", 64'(acc), 64'd0);
        chk("t3_ready_full", 64'(cmd_ready), 64'd0);
        idle_cmd();
        exp_tail();
        go_run(32'd100, 32'd9, 32'd0);
        wait_done("t3", 300);
        chk("t3_spins", 64'(spins), 64'hB6);
        idle_cycles(3);
        check_log("t3", 0);
        chk("t3_ready_after", 64'(cmd_ready), 64'd1);

        // go together with the first push: that entry belongs to this run
        clear_logs();
        exp_head(32'd100, 32'd2);
        exp_w(3'd5, 3'd6, 32'd77);
        exp_tail();
        @(negedge clk);
        go = 1; cutoff = 32'd100; ctr_max = 32'd2; run_cycles = 32'd3;
        cmd_valid = 1; cmd_i = 3'd5; cmd_j = 3'd6; cmd_w = 32'd77;
        @(negedge clk);
        go = 0; cmd_valid = 0;
        wait_done("t7", 300);
        idle_cycles(3);
        check_log("t7", 3);

        // Reset during RUN drops the queue and the run
        clear_logs();
        push(3'd1, 3'd2, 32'd5, acc);
        push(3'd2, 3'd1, 32'd6, acc);
        idle_cmd();
        go_run(32'd1, 32'd1, 32'd200);
        idle_cycles(40);
        push(3'd0, 3'd1, 32'd11, acc);
        chk("t5_push_in_run", 64'(acc), 64'd1);
        push(3'd0, 3'd2, 32'd12, acc);
        idle_cmd();
        @(negedge clk);
        axi_rstn = 0;
        @(negedge clk);
        axi_rstn = 1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_wready", 64'(wready), 64'd0);
        chk("t5_wr_addr", 64'(wr_addr), 64'd0);
        chk("t5_araddr", 64'(araddr), 64'd0);
        chk("t5_spins", 64'(spins), 64'd0);
        clear_logs();
        exp_head(32'd100, 32'd3);
        exp_tail();
        go_run(32'd100, 32'd3, 32'd4);
        wait_done("t5", 300);
        chk("t5_spins_after", 64'(spins), 64'hB6);
        idle_cycles(3);
        check_log("t5", 4);
        check_reads("t5");
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);

        // go during RUN is ignored (its cutoff of 0 would give all ones)
        clear_logs();
        push(3'd7, 3'd0, 32'd42, acc);
        idle_cmd();
        exp_head(32'd100, 32'd5);
        exp_w(3'd7, 3'd0, 32'd42);
        exp_tail();
        go_run(32'd100, 32'd5, 32'd60);
        idle_cycles(20);
        go_run(32'd0, 32'd6, 32'd7);
        wait_done("t6", 300);
        idle_cycles(80);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_spins_hold", 64'(spins), 64'hB6);
        check_log("t6", 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
